// File: rtl/motoro3_pkg.sv
// Shared constants, FSM state type and the |sin| step table for the 3-phase step sequencer.
package motoro3_pkg;

  localparam logic [3:0]  SG_STEP_IDLE   = 4'd15;
  localparam logic [3:0]  SG_STEP_LAST   = 4'd11;
  localparam int unsigned PERIOD_MIN_DEF = 4;
  localparam int unsigned NUM_STEPS      = 12;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } m3_state_e;

  // 8-bit |sin| sampled at 15 deg + 30 deg * k, one entry per commutation step
  localparam logic [7:0] SINE_TABLE [NUM_STEPS] = '{
    8'd66, 8'd180, 8'd246, 8'd246, 8'd180, 8'd66,
    8'd66, 8'd180, 8'd246, 8'd246, 8'd180, 8'd66
  };

endpackage

// File: rtl/motoro3_step_sine_rom.sv
// Combinational step-index to |sin| lookup; out-of-range steps read as zero.
module motoro3_step_sine_rom
  import motoro3_pkg::*;
(
  input  logic [3:0] step,
  output logic [7:0] sine
);

  // Table lookup by step index
  always_comb begin
    sine = '0;
    for (int i = 0; i < int'(NUM_STEPS); i++) begin
      if (step == 4'(i)) sine = SINE_TABLE[i];
    end
  end

endmodule

// File: rtl/motoro3_step_sequencer.sv
// 12-step commutation timebase feeding the PWM generator.
// Build option M3_STEP_SINE_EN: when defined, the per-step pulse budget is the amplitude
// scaled by the |sin| table; otherwise the amplitude is passed through (block commutation).
module motoro3_step_sequencer
  import motoro3_pkg::*;
#(
  parameter int unsigned PERIOD_MIN = PERIOD_MIN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m3r_runEn,
  input  logic [24:0] m3r_stepPeriod,
  input  logic [15:0] m3r_pwmAmp,
  output logic [3:0]  sgStep,
  output logic [24:0] m3cnt,
  output logic        m3cntFirst1,
  output logic        m3cntFirst2,
  output logic        m3cntLast2,
  output logic        m3cntLast1,
  output logic        pwmActive1,
  output logic [15:0] pwmLENpos,
  output logic [15:0] m3revCnt
);

  localparam logic [24:0] PeriodMinW = 25'(PERIOD_MIN);

  m3_state_e   state_q, state_d;
  logic [24:0] cnt_q;
  logic [24:0] period_q;
  logic [3:0]  step_q;
  logic [15:0] len_q;
  logic [15:0] rev_q;

  logic        at_last;
  logic        start;
  logic        boundary;
  logic        stop;
  logic [3:0]  next_step;
  logic [24:0] period_clamped;
  logic [15:0] len_next;

  assign at_last        = (cnt_q == period_q - 25'd1);
  assign period_clamped = (m3r_stepPeriod < PeriodMinW) ? PeriodMinW : m3r_stepPeriod;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state: DRAIN only leaves to IDLE on the final cycle of the step in progress
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (m3r_runEn) state_d = StRun;
      StRun:   if (!m3r_runEn) state_d = StDrain;
      StDrain: begin
        if (m3r_runEn)    state_d = StRun;
        else if (at_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state; strobes gated so IDLE shows none
  always_comb begin
    pwmActive1  = (state_q != StIdle);
    m3cntFirst1 = pwmActive1 && (cnt_q == 25'd0);
    m3cntFirst2 = pwmActive1 && (cnt_q == 25'd1);
    m3cntLast2  = pwmActive1 && at_last;
    m3cntLast1  = pwmActive1 && (cnt_q == period_q - 25'd2);
  end

  // Step-boundary decode shared by the datapath
  always_comb begin
    start     = (state_q == StIdle) && m3r_runEn;
    boundary  = (state_q != StIdle) && at_last && (state_d != StIdle);
    stop      = (state_q == StDrain) && at_last && (state_d == StIdle);
    next_step = '0;
    if (!start && (step_q != SG_STEP_LAST)) next_step = step_q + 4'd1;
  end

`ifdef M3_STEP_SINE_EN
  logic [7:0]  sine_val;
  logic [23:0] prod;

  motoro3_step_sine_rom u_rom (
    .step (next_step),
    .sine (sine_val)
  );

  // 16x8 product; budget is the top 16 bits
  always_comb begin
    prod     = {8'd0, m3r_pwmAmp} * {16'd0, sine_val};
    len_next = 16'(prod >> 8);
  end
`else
  // Block commutation: full amplitude on every active step
  always_comb begin
    len_next = m3r_pwmAmp;
  end
`endif

  // Counter, step, latched period/budget and revolution count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= PeriodMinW;
      step_q   <= SG_STEP_IDLE;
      len_q    <= '0;
      rev_q    <= '0;
    end else if (start || boundary) begin
      cnt_q    <= '0;
      period_q <= period_clamped;
      step_q   <= next_step;
      len_q    <= len_next;
      if (boundary && (step_q == SG_STEP_LAST)) rev_q <= rev_q + 16'd1;
    end else if (stop) begin
      cnt_q  <= '0;
      step_q <= SG_STEP_IDLE;
      len_q  <= '0;
    end else if (state_q != StIdle) begin
      cnt_q <= cnt_q + 25'd1;
    end
  end

  assign sgStep    = step_q;
  assign m3cnt     = cnt_q;
  assign pwmLENpos = len_q;
  assign m3revCnt  = rev_q;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Directed bench for motoro3_step_sequencer; expectations are hand-derived per step.
module tb_motoro3_step_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        m3r_runEn;
  logic [24:0] m3r_stepPeriod;
  logic [15:0] m3r_pwmAmp;
  logic [3:0]  sgStep;
  logic [24:0] m3cnt;
  logic        m3cntFirst1, m3cntFirst2, m3cntLast2, m3cntLast1;
  logic        pwmActive1;
  logic [15:0] pwmLENpos;
  logic [15:0] m3revCnt;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned exp_rev = 0;

  motoro3_step_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .m3r_runEn      (m3r_runEn),
    .m3r_stepPeriod (m3r_stepPeriod),
    .m3r_pwmAmp     (m3r_pwmAmp),
    .sgStep         (sgStep),
    .m3cnt          (m3cnt),
    .m3cntFirst1    (m3cntFirst1),
    .m3cntFirst2    (m3cntFirst2),
    .m3cntLast2     (m3cntLast2),
    .m3cntLast1     (m3cntLast1),
    .pwmActive1     (pwmActive1),
    .pwmLENpos      (pwmLENpos),
    .m3revCnt       (m3revCnt)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_len(input int step, input logic [15:0] amp);
`ifdef M3_STEP_SINE_EN
    int unsigned t;
    int unsigned p;
    case (step % 6)
      0, 5:    t = 66;
      1, 4:    t = 180;
      default: t = 246;
    endcase
    p = 32'(amp) * t;
    return 16'(p >> 8);
`else
    return amp;
`endif
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_step"}, 64'(sgStep), 64'd15);
    chk({tag, "_cnt"}, 64'(m3cnt), 64'd0);
    chk({tag, "_strb"}, 64'({m3cntFirst1, m3cntFirst2, m3cntLast1, m3cntLast2}), 64'd0);
    chk({tag, "_act"}, 64'(pwmActive1), 64'd0);
    chk({tag, "_len"}, 64'(pwmLENpos), 64'd0);
    chk({tag, "_rev"}, 64'(m3revCnt), 64'(exp_rev));
  endtask

  // Walk one whole step; optionally drop/raise run after the check at a given count
  task automatic run_step(input int step, input int per, input logic [15:0] amp,
                          input int drop_at, input int raise_at);
    for (int c = 0; c < per; c++) begin
      chk("step", 64'(sgStep), 64'(step));
      chk("cnt", 64'(m3cnt), 64'(c));
      chk("strobes", 64'({m3cntFirst1, m3cntFirst2, m3cntLast1, m3cntLast2}),
          64'({c == 0, c == 1, c == per - 2, c == per - 1}));
      chk("active", 64'(pwmActive1), 64'd1);
      chk("len", 64'(pwmLENpos), 64'(exp_len(step, amp)));
      chk("rev", 64'(m3revCnt), 64'(exp_rev));
      if (c == drop_at) m3r_runEn = 1'b0;
      if (c == raise_at) m3r_runEn = 1'b1;
      tick();
    end
  endtask

  initial begin
    rst            = 1'b1;
    m3r_runEn      = 1'b0;
    m3r_stepPeriod = 25'd10;
    m3r_pwmAmp     = 16'h1000;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;

    // Idle with run low
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_idle("idle");
    end

    // Start: step 0 visible one cycle after run is sampled
    m3r_runEn = 1'b1;
    tick();
    chk("start_first1", 64'(m3cntFirst1), 64'd1);

    // 24 steps at period 10, two 11->0 wraps
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 12; s++) begin
        run_step(s, 10, 16'h1000, -1, -1);
        if (s == 11) exp_rev++;
      end
    end
    chk("rev_after_24", 64'(m3revCnt), 64'd2);

    // Period 2 clamps to 4 from the next boundary; amplitude change likewise deferred
    m3r_stepPeriod = 25'd2;
    run_step(0, 10, 16'h1000, -1, -1);
    m3r_pwmAmp = 16'h8000;
    run_step(1, 4, 16'h1000, -1, -1);
    m3r_stepPeriod = 25'd10;
    run_step(2, 4, 16'h8000, -1, -1);

    // Drop run at count 3: step 3 completes, then IDLE
    run_step(3, 10, 16'h8000, 3, -1);
    chk_idle("drain_idle");
    tick();
    chk_idle("drain_idle2");

    // Restart, drop and restore inside step 0: no gap in the sequence
    m3r_runEn = 1'b1;
    tick();
    run_step(0, 10, 16'h8000, 2, 5);
    run_step(1, 10, 16'h8000, -1, -1);
    run_step(2, 10, 16'h8000, -1, -1);
    run_step(3, 10, 16'h8000, -1, -1);
    run_step(4, 10, 16'h8000, -1, -1);

    // Reset mid-step 5
    for (int c = 0; c < 4; c++) begin
      chk("s5_step", 64'(sgStep), 64'd5);
      chk("s5_cnt", 64'(m3cnt), 64'(c));
      tick();
    end
    rst       = 1'b1;
    m3r_runEn = 1'b0;
    exp_rev   = 0;
    tick();
    chk_idle("mid_rst");
    rst = 1'b0;
    tick();
    chk_idle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
